key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive clock cycles a synchronized key must differ from its debounced state before that state changes (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter HOLD_CYCLES, default 50_000_000: cycles a debounced key must stay pressed before a long-press pulse is issued (1 s at 50 MHz); legal range >= 2.
REQ-003 clk  input  1  system clock; one clock domain; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 KEY  input  4  raw board pushbuttons, active-low (0 = pressed), asynchronous to clk.
REQ-006 key_down  output  4  debounced level per key, active-high (1 = pressed).
REQ-007 key_press  output  4  one-cycle pulse per key on a debounced press.
REQ-008 key_release  output  4  one-cycle pulse per key on a debounced release.
REQ-009 key_long  output  4  one-cycle pulse per key when held for HOLD_CYCLES.
REQ-010 any_press  output  1  OR of key_press[3:0]; feeds the game state machine's advance condition.

Function
REQ-011 Each KEY bit SHALL be inverted and passed through a 2-flop synchronizer; no logic SHALL sample KEY before the second flop.
REQ-012 Each key SHALL have an independent debounce counter, cleared on any cycle where the synchronized value equals key_down.
REQ-013 While the synchronized value differs from key_down, the counter SHALL increment; on the cycle it would reach DEBOUNCE_CYCLES, key_down SHALL toggle and the counter SHALL clear.
REQ-014 A single-cycle glitch (shorter than DEBOUNCE_CYCLES) SHALL clear the counter and never change key_down.
REQ-015 Latency: a clean KEY edge arriving before edge 1 SHALL make key_down change on rising edge 2+DEBOUNCE_CYCLES.
REQ-016 key_press/key_release SHALL be registered and asserted for exactly the one cycle following the key_down 0->1 / 1->0 transition edge, i.e. coincident with the new key_down value.
REQ-017 Per-key hold counter SHALL clear while key_down=0 and increment while key_down=1, saturating at HOLD_CYCLES.
REQ-018 key_long SHALL pulse once, in the cycle the hold counter first reaches HOLD_CYCLES; no further pulse until a release and new press.
REQ-019 A release before HOLD_CYCLES SHALL produce key_release only, no key_long.
REQ-020 Keys SHALL be fully independent; simultaneous presses on multiple keys SHALL pulse all corresponding key_press bits in the same cycle.
REQ-021 Counter widths SHALL be $clog2 of the respective parameter plus one; no wrap-around permitted.
REQ-022 any_press SHALL be combinational OR of registered key_press (no added latency).

Reset
REQ-023 On reset: synchronizer flops = 0 (released), key_down = 0, all counters = 0, key_press/key_release/key_long/any_press = 0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort it; after release, a key physically held down SHALL be re-qualified from zero and generate a fresh key_press after 2+DEBOUNCE_CYCLES cycles.
REQ-025 No output pulse SHALL occur in the cycle reset is asserted.

Structure
REQ-026 Shared package holds default DEBOUNCE_CYCLES, HOLD_CYCLES, key index constants (KEY_CONFIRM=0, KEY_BACK=1, KEY_P1=2, KEY_P2=3) and CLK_HZ = 50_000_000.
REQ-027 One sub-module, key_debounce (single key: sync, debounce, edge, hold), instantiated four times; key_conditioner adds only the generate loop and any_press.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-028 KEY[0] driven 1->0 before edge 1, held -> key_down[0]=1 and key_press[0]=1 for one cycle at edge 6; any_press=1 same cycle.
REQ-029 KEY[1] low for 3 cycles then high -> key_down[1], key_press[1] stay 0 throughout.
REQ-030 KEY[2] held low 20 cycles -> key_press[2] at edge 6, single key_long[2] at edge 16, no second pulse; release -> key_release[2] 6 cycles after release edge.
REQ-031 KEY[3:0]=4'b0000 simultaneously -> key_press=4'b1111 in one cycle, any_press=1 for exactly one cycle.
REQ-032 KEY[0] held low, reset pulsed at edge 4 for one cycle -> no key_press before reset; key_press[0] at 2+4 cycles after reset deasserts.
REQ-033 KEY[0] bouncing 0/1 every cycle for 10 cycles then stable low -> exactly one key_press[0], 6 cycles after last transition.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared constants for the pushbutton conditioner: clock rate, default timing, key roles.
package key_conditioner_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned NUM_KEYS            = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
    localparam int unsigned DEF_HOLD_CYCLES     = CLK_HZ;

    localparam int unsigned KEY_CONFIRM = 0;
    localparam int unsigned KEY_BACK    = 1;
    localparam int unsigned KEY_P1      = 2;
    localparam int unsigned KEY_P2      = 3;

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton: 2-flop synchronizer, counter debounce, press/release edges, long-press pulse.
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_down,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;

    logic              sync_q1;
    logic              sync_q2;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              differ_c;
    logic              db_hit_c;
    logic              hold_hit_c;
    logic              hold_full_c;

    // The counter would reach DEBOUNCE_CYCLES this cycle: toggle instead of storing it.
    always_comb begin
        differ_c    = (sync_q2 != key_down);
        db_hit_c    = differ_c && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        hold_hit_c  = key_down && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
        hold_full_c = (hold_cnt == HOLD_W'(HOLD_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            sync_q1 <= ~key_n;
            sync_q2 <= sync_q1;

            if (!differ_c || db_hit_c) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            key_down    <= key_down ^ db_hit_c;
            key_press   <= db_hit_c && !key_down;
            key_release <= db_hit_c && key_down;

            // Hold counter saturates so the long pulse fires once per press.
            if (!key_down) begin
                hold_cnt <= '0;
            end else if (!hold_full_c) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            key_long <= hold_hit_c;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Four independent conditioned pushbuttons plus an any-press strobe for the game FSM.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    output logic [3:0] key_down,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic       any_press
);

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_key (
            .clk         (clk),
            .reset       (reset),
            .key_n       (KEY[i]),
            .key_down    (key_down[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

    assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [3:0] key_down;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic       any_press;

    key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .KEY         (KEY),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  key;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Expected {key_down, key_press, key_release, key_long, any_press}.
    function automatic logic [16:0] mk(input logic [3:0] d, input logic [3:0] p,
                                       input logic [3:0] r, input logic [3:0] l);
        return {d, p, r, l, |p};
    endfunction

    function automatic void add(input logic rst, input logic [3:0] key, input logic [16:0] exp);
        vec_t v;
        v.rst = rst;
        v.key = key;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int cyc, input logic [16:0] exp);
        logic [16:0] got;
        got = {key_down, key_press, key_release, key_long, any_press};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s edge %0d: got down/press/rel/long/any=%h/%h/%h/%h/%b expected %h/%h/%h/%h/%b",
                     name, cyc, got[16:13], got[12:9], got[8:5], got[4:1], got[0],
                     exp[16:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        KEY   = 4'hF;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset, then KEY[0] pressed edges 1..8, released from edge 9; too short for a long press.
        add(1'b1, 4'hF, mk(4'h0, 4'h0, 4'h0, 4'h0));
        add(1'b1, 4'hF, mk(4'h0, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hE, mk(4'h0, 4'h0, 4'h0, 4'h0));   // edge 1
        add(1'b0, 4'hE, mk(4'h0, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hE, mk(4'h0, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hE, mk(4'h0, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hE, mk(4'h0, 4'h0, 4'h0, 4'h0));   // edge 5
        add(1'b0, 4'hE, mk(4'h1, 4'h1, 4'h0, 4'h0));   // edge 6: press
        add(1'b0, 4'hE, mk(4'h1, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hE, mk(4'h1, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hF, mk(4'h1, 4'h0, 4'h0, 4'h0));   // edge 9: released
        add(1'b0, 4'hF, mk(4'h1, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hF, mk(4'h1, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hF, mk(4'h1, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hF, mk(4'h1, 4'h0, 4'h0, 4'h0));
        add(1'b0, 4'hF, mk(4'h0, 4'h0, 4'h1, 4'h0));   // edge 14: release
        add(1'b0, 4'hF, mk(4'h0, 4'h0, 4'h0, 4'h0));

        reset = 1'b1;
        KEY   = 4'hF;
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            KEY   = tbl[i].key;
            tick();
            check("table", i, tbl[i].exp);
        end

        // Three-cycle glitch on KEY[1] never qualifies.
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            KEY = (e <= 3) ? 4'hD : 4'hF;
            tick();
            check("glitch_k1", e, mk(4'h0, 4'h0, 4'h0, 4'h0));
        end

        // KEY[2] held 20 cycles: press at 6, single long at 16, release at 26.
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            KEY = (e <= 20) ? 4'hB : 4'hF;
            tick();
            check("hold_k2", e, mk((e >= 6 && e <= 25) ? 4'h4 : 4'h0,
                                   (e == 6)  ? 4'h4 : 4'h0,
                                   (e == 26) ? 4'h4 : 4'h0,
                                   (e == 16) ? 4'h4 : 4'h0));
        end

        // All four keys pressed together.
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            KEY = 4'h0;
            tick();
            check("all_keys", e, mk((e >= 6) ? 4'hF : 4'h0,
                                    (e == 6) ? 4'hF : 4'h0, 4'h0, 4'h0));
        end

        // Reset at edge 4 while KEY[0] held: re-qualifies, press at edge 10.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            reset = (e == 4);
            KEY   = 4'hE;
            tick();
            check("reset_mid", e, mk((e >= 10) ? 4'h1 : 4'h0,
                                     (e == 10) ? 4'h1 : 4'h0, 4'h0, 4'h0));
        end
        reset = 1'b0;

        // KEY[0] bounces every cycle for 10 cycles, stable low from edge 11: one press at 16.
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            KEY = (e <= 10 && (e % 2 == 0)) ? 4'hF : 4'hE;
            tick();
            check("bounce_k0", e, mk((e >= 16) ? 4'h1 : 4'h0,
                                     (e == 16) ? 4'h1 : 4'h0, 4'h0, 4'h0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
